// File: rtl/mpu_pkg.sv
// Shared definitions for the fetch path: FSM encoding, opcodes, PC-control bundle
// and the opcode-to-PC-control decode helper.
package mpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STEP  = 2'd3
  } fetch_state_e;

  localparam logic [3:0] OP_JMP        = 4'hF;
  localparam logic [3:0] OP_BRA        = 4'hE;
  localparam logic [7:0] RESET_VEC_DEF = 8'h00;

  typedef struct packed {
    logic       br;
    logic       nia;
    logic [7:0] imm;
  } pc_ctrl_t;

  // br=1 with nia=0 is never produced, so the PC never sees that combination.
  function automatic pc_ctrl_t decode_pc_ctrl(input logic [15:0] word);
    pc_ctrl_t c;
    case (word[15:12])
      OP_JMP: begin
        c.br  = 1'b0;
        c.nia = 1'b0;
        c.imm = word[7:0];
      end
      OP_BRA: begin
        c.br  = 1'b1;
        c.nia = 1'b1;
        c.imm = word[7:0];
      end
      default: begin
        c.br  = 1'b0;
        c.nia = 1'b1;
        c.imm = 8'h00;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular instruction queue; the head entry is presented directly on rdata.
module instr_fifo
  import mpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_s;

  // Explicit wrap keeps non-power-of-two depths (3) correct.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return PW'(0);
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign pop_s = pop && valid;
  assign valid = (count_q != CW'(0));
  assign full  = (count_q == CW'(DEPTH));
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: boots the PC, issues one memory read at a time,
// decodes the returned word into a PC step and queues it for the decoder.
module fetch_ctrl
  import mpu_pkg::*;
#(
  parameter logic [7:0] RESET_VEC = RESET_VEC_DEF,
  parameter int         QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pc,
  output logic        pc_step,
  output logic        br,
  output logic        nia,
  output logic [7:0]  imm,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  input  logic        dec_ready
);

  fetch_state_e state_q, state_d;
  logic         mem_req_q, mem_req_d;
  logic [7:0]   mem_addr_q, mem_addr_d;
  logic         pc_step_q, pc_step_d;
  logic         br_q, br_d;
  logic         nia_q, nia_d;
  logic [7:0]   imm_q, imm_d;
  logic         push_s;
  logic         pop_s;
  logic         fifo_full_s;
  pc_ctrl_t     dec_s;

  assign push_s = (state_q == ST_WAIT) && mem_ack;
  assign pop_s  = instr_valid && dec_ready;
  assign dec_s  = decode_pc_ctrl(mem_rdata);

  instr_fifo #(
    .WIDTH (16),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (mem_rdata),
    .pop   (pop_s),
    .rdata (instr),
    .valid (instr_valid),
    .full  (fifo_full_s)
  );

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    pc_step_d  = 1'b0;
    br_d       = 1'b0;
    nia_d      = 1'b0;
    imm_d      = 8'h00;
    case (state_q)
      ST_BOOT: begin
        state_d   = ST_FETCH;
        pc_step_d = 1'b1;
        imm_d     = RESET_VEC;
      end
      ST_FETCH: begin
        // Hold issue while the boot PC load is still in flight, so pc is current.
        if (!fifo_full_s && !pc_step_q) begin
          state_d    = ST_WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = pc;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          state_d   = ST_STEP;
          mem_req_d = 1'b0;
          pc_step_d = 1'b1;
          br_d      = dec_s.br;
          nia_d     = dec_s.nia;
          imm_d     = dec_s.imm;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_STEP: begin
        state_d = ST_FETCH;
      end
      default: begin
        state_d   = ST_BOOT;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 8'h00;
      pc_step_q  <= 1'b0;
      br_q       <= 1'b0;
      nia_q      <= 1'b0;
      imm_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      pc_step_q  <= pc_step_d;
      br_q       <= br_d;
      nia_q      <= nia_d;
      imm_q      <= imm_d;
    end
  end

  assign pc_step  = pc_step_q;
  assign br       = br_q;
  assign nia      = nia_q;
  assign imm      = imm_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot, fetch/decode, backpressure, push+pop, reset mid-read.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pc;
  logic        pc_step;
  logic        br;
  logic        nia;
  logic [7:0]  imm;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic        dec_ready;

  int total = 0;
  int bad   = 0;

  fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .pc_step     (pc_step),
    .br          (br),
    .nia         (nia),
    .imm         (imm),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .dec_ready   (dec_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the bench owns the PC register and applies any pc_step it saw.
  task automatic tick();
    logic [7:0] nxt;
    nxt = pc;
    if (pc_step === 1'b1) begin
      if (nia === 1'b0)     nxt = imm;
      else if (br === 1'b1) nxt = pc + imm;
      else                  nxt = pc + 8'd1;
    end
    @(posedge clk);
    #1;
    pc = nxt;
  endtask

  task automatic wait_req(input string tag, input int bound);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, mem_req}, 32'd1);
  endtask

  // Reset has just been released; a stray ack may be pending on mem_ack.
  task automatic boot_seq(input string pfx);
    tick();
    mem_ack = 1'b0;
    chk({pfx, "_step"},  {31'd0, pc_step},     32'd1);
    chk({pfx, "_br"},    {31'd0, br},          32'd0);
    chk({pfx, "_nia"},   {31'd0, nia},         32'd0);
    chk({pfx, "_imm"},   {24'd0, imm},         32'h00);
    chk({pfx, "_qempty"},{31'd0, instr_valid}, 32'd0);
    chk({pfx, "_noreq"}, {31'd0, mem_req},     32'd0);
    tick();
    chk({pfx, "_step_off"}, {31'd0, pc_step},  32'd0);
    wait_req({pfx, "_req"}, 2);
    chk({pfx, "_addr"},  {24'd0, mem_addr},    {24'd0, pc});
    chk({pfx, "_addr0"}, {24'd0, mem_addr},    32'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    pc        = 8'hA5;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    dec_ready = 1'b0;
    tick();
    tick();
    chk("rst_pc_step",  {31'd0, pc_step},     32'd0);
    chk("rst_br",       {31'd0, br},          32'd0);
    chk("rst_nia",      {31'd0, nia},         32'd0);
    chk("rst_imm",      {24'd0, imm},         32'h00);
    chk("rst_mem_req",  {31'd0, mem_req},     32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr},    32'h00);
    chk("rst_valid",    {31'd0, instr_valid}, 32'd0);
    chk("rst_instr",    {16'd0, instr},       32'h0000);

    rst_n = 1'b1;
    boot_seq("boot");

    // Sequential word
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_ack = 1'b0;
    chk("seq_step",  {31'd0, pc_step},     32'd1);
    chk("seq_br",    {31'd0, br},          32'd0);
    chk("seq_nia",   {31'd0, nia},         32'd1);
    chk("seq_imm",   {24'd0, imm},         32'h00);
    chk("seq_valid", {31'd0, instr_valid}, 32'd1);
    chk("seq_instr", {16'd0, instr},       32'h1234);
    chk("seq_req_drop", {31'd0, mem_req},  32'd0);
    tick();
    chk("seq_step_once", {31'd0, pc_step}, 32'd0);
    chk("seq_idle_nia",  {31'd0, nia},     32'd0);
    wait_req("seq_next_req", 2);
    chk("seq_next_addr", {24'd0, mem_addr}, 32'h01);

    // Jump; queue becomes full
    mem_ack = 1'b1; mem_rdata = 16'hF040;
    tick();
    mem_ack = 1'b0;
    chk("jmp_step",  {31'd0, pc_step}, 32'd1);
    chk("jmp_br",    {31'd0, br},      32'd0);
    chk("jmp_nia",   {31'd0, nia},     32'd0);
    chk("jmp_imm",   {24'd0, imm},     32'h40);
    chk("jmp_head",  {16'd0, instr},   32'h1234);
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    chk("full_noreq0", {31'd0, mem_req}, 32'd0);
    chk("stray_nostep", {31'd0, pc_step}, 32'd0);
    tick();
    chk("full_noreq1", {31'd0, mem_req}, 32'd0);
    tick();
    chk("full_noreq2", {31'd0, mem_req}, 32'd0);

    // Single pop releases one slot, next read follows
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("pop1_valid", {31'd0, instr_valid}, 32'd1);
    chk("pop1_instr", {16'd0, instr},       32'hF040);
    chk("pop1_noreq", {31'd0, mem_req},     32'd0);
    tick();
    chk("pop1_req",  {31'd0, mem_req},  32'd1);
    chk("pop1_addr", {24'd0, mem_addr}, 32'h40);

    // Branch -2
    mem_ack = 1'b1; mem_rdata = 16'hE0FE;
    tick();
    mem_ack = 1'b0;
    chk("bra_step", {31'd0, pc_step}, 32'd1);
    chk("bra_br",   {31'd0, br},      32'd1);
    chk("bra_nia",  {31'd0, nia},     32'd1);
    chk("bra_imm",  {24'd0, imm},     32'hFE);
    dec_ready = 1'b1;
    tick();
    chk("drain_instr", {16'd0, instr}, 32'hE0FE);
    tick();
    dec_ready = 1'b0;
    chk("drain_empty", {31'd0, instr_valid}, 32'd0);
    chk("bra_req",     {31'd0, mem_req},     32'd1);
    chk("bra_addr",    {24'd0, mem_addr},    32'h3E);

    // Push and pop together with one entry queued
    mem_ack = 1'b1; mem_rdata = 16'hA111;
    tick();
    mem_ack = 1'b0;
    chk("pp_first", {16'd0, instr}, 32'hA111);
    wait_req("pp_req", 3);
    chk("pp_addr", {24'd0, mem_addr}, 32'h3F);
    chk("pp_older", {16'd0, instr}, 32'hA111);
    mem_ack = 1'b1; mem_rdata = 16'hA222; dec_ready = 1'b1;
    tick();
    mem_ack = 1'b0; dec_ready = 1'b0;
    chk("pp_valid", {31'd0, instr_valid}, 32'd1);
    chk("pp_newer", {16'd0, instr},       32'hA222);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("pp_count1", {31'd0, instr_valid}, 32'd0);

    // Reset in the middle of a read, then a stale ack
    wait_req("mid_req", 3);
    chk("mid_addr", {24'd0, mem_addr}, 32'h40);
    #1;
    rst_n = 1'b0;
    pc    = 8'hA5;
    #1;
    chk("mid_async_req",  {31'd0, mem_req},  32'd0);
    chk("mid_async_addr", {24'd0, mem_addr}, 32'h00);
    tick();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    boot_seq("reboot");
    chk("reboot_nopush", {31'd0, instr_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
